// File: rtl/reset_sequencer_if.sv
// Reset request / per-domain reset bundle shared by the sequencer and its consumers.
// Optional cause reporting signals exist only when RESET_SEQUENCER_CAUSE_EN is defined.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 3
);
  logic                  btn_req;
  logic                  sw_req;
  logic                  wdt_req;
  logic [NUM_STAGES-1:0] rst_n_out;
  logic                  busy;
`ifdef RESET_SEQUENCER_CAUSE_EN
  logic [3:0]            cause;
  logic                  cause_clr;

  modport master (output btn_req, sw_req, wdt_req, cause_clr,
                  input  rst_n_out, busy, cause);
  modport slave  (input  btn_req, sw_req, wdt_req, cause_clr,
                  output rst_n_out, busy, cause);
`else
  modport master (output btn_req, sw_req, wdt_req,
                  input  rst_n_out, busy);
  modport slave  (input  btn_req, sw_req, wdt_req,
                  output rst_n_out, busy);
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges button/software/watchdog requests, holds all domains in reset,
// then releases them one by one. Define RESET_SEQUENCER_CAUSE_EN for sticky reset-cause reporting.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned STAGE_GAP   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  reset_sequencer_if.slave bus
);

  localparam int unsigned MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CW      = $clog2(MAX_CNT + 1);
  localparam int unsigned SW      = $clog2(NUM_STAGES + 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [SW-1:0]         stage;
  logic [NUM_STAGES-1:0] rst_q;
  logic                  busy_q;
  logic                  btn_meta;
  logic                  btn_s;
  logic                  req_d;
  logic                  req;

  // Two-flop synchronizer for the asynchronous button input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
    end else begin
      btn_meta <= bus.btn_req;
      btn_s    <= btn_meta;
    end
  end

  assign req = btn_s | bus.sw_req | bus.wdt_req;

  // Sequencer FSM; req_d keeps the hold counter cleared for the cycle after a request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_ASSERT;
      count  <= '0;
      stage  <= '0;
      rst_q  <= '0;
      busy_q <= 1'b1;
      req_d  <= 1'b0;
    end else begin
      req_d <= req;
      if (req && (state != ST_ASSERT)) begin
        rst_q  <= '0;
        busy_q <= 1'b1;
        count  <= '0;
        stage  <= '0;
        state  <= ST_ASSERT;
      end else begin
        case (state)
          ST_ASSERT: begin
            if (req || req_d) begin
              count <= '0;
            end else if (count == CW'(HOLD_CYCLES - 1)) begin
              rst_q <= NUM_STAGES'(1);
              stage <= SW'(1);
              count <= '0;
              if (NUM_STAGES == 1) begin
                state  <= ST_RUN;
                busy_q <= 1'b0;
              end else begin
                state  <= ST_RELEASE;
              end
            end else begin
              count <= count + CW'(1);
            end
          end
          ST_RELEASE: begin
            if (count == CW'(STAGE_GAP - 1)) begin
              rst_q <= rst_q | (NUM_STAGES'(1) << stage);
              stage <= stage + SW'(1);
              count <= '0;
              if (stage == SW'(NUM_STAGES - 1)) begin
                state  <= ST_RUN;
                busy_q <= 1'b0;
              end
            end else begin
              count <= count + CW'(1);
            end
          end
          ST_RUN: begin
            rst_q  <= '1;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= ST_ASSERT;
            rst_q  <= '0;
            busy_q <= 1'b1;
            count  <= '0;
            stage  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.rst_n_out = rst_q;
  assign bus.busy      = busy_q;

`ifdef RESET_SEQUENCER_CAUSE_EN
  logic [3:0] cause_q;

  // Sticky cause bits; a request in the clearing cycle still sets its bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= 4'b1000;
    end else begin
      cause_q <= (bus.cause_clr ? 4'b0000 : cause_q) | {1'b0, bus.wdt_req, bus.sw_req, btn_s};
    end
  end

  assign bus.cause = cause_q;
`endif

endmodule
